// File: rtl/seq_chunk_adder_pkg.sv
// Shared FSM state encodings and index-width helper for the chunked sequential adder.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int idx_width(input int num_chunks);
    return (num_chunks <= 1) ? 1 : $clog2(num_chunks);
  endfunction

endpackage

// File: rtl/seq_chunk_adder_rca_chunk.sv
// CHUNK-bit combinational ripple-carry slice; zero latency, no flow control.
module rca_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  always_comb begin
    logic carry;
    sum   = '0;
    carry = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder, CHUNK bits per clock; out_valid NUM_CHUNKS edges after accept, result held until out_ready.
// Optional subtract mode (a + ~b + 1) enabled by defining SEQ_CHUNK_ADDER_SUB_EN.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IDX_W      = idx_width(NUM_CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             cout_q, out_valid_q, in_ready_q;

  logic [WIDTH-1:0] b_d;
  logic             carry_d;
  logic [CHUNK-1:0] slice_a, slice_b, slice_sum;
  logic             slice_cout;

  // Subtraction folds into the add: invert b at latch time and force carry-in to 1.
  always_comb begin
    b_d     = b;
    carry_d = cin;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    if (sub) begin
      b_d     = ~b;
      carry_d = 1'b1;
    end
`endif
  end

  assign slice_a = a_q[idx_q*CHUNK +: CHUNK];
  assign slice_b = b_q[idx_q*CHUNK +: CHUNK];

  rca_chunk #(.CHUNK(CHUNK)) u_rca (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b_d;
            carry_q    <= carry_d;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q[idx_q*CHUNK +: CHUNK] <= slice_sum;
          carry_q <= slice_cout;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            cout_q      <= slice_cout;
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: main CHUNK=8 instance plus CHUNK sweep instances.
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, cin, in_ready, out_valid, cout;
  logic [63:0] a, b, sum;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  logic        sub;
`endif

  logic        sv_in_valid [3];
  logic        sv_in_ready [3];
  logic        sv_out_valid[3];
  logic        sv_cin      [3];
  logic        sv_cout     [3];
  logic [63:0] sv_a        [3];
  logic [63:0] sv_b        [3];
  logic [63:0] sv_sum      [3];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(64), .CHUNK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int CH = (g == 0) ? 1 : ((g == 1) ? 16 : 64);
    seq_chunk_adder #(.WIDTH(64), .CHUNK(CH)) u_sw (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (sv_in_valid[g]),
      .in_ready  (sv_in_ready[g]),
      .a         (sv_a[g]),
      .b         (sv_b[g]),
      .cin       (sv_cin[g]),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
      .sub       (1'b0),
`endif
      .out_valid (sv_out_valid[g]),
      .out_ready (1'b1),
      .sum       (sv_sum[g]),
      .cout      (sv_cout[g])
    );
  end

  // Present one operand set and hold in_valid for exactly the accepting edge.
  task automatic issue(input logic [63:0] ta, input logic [63:0] tb, input logic tcin, input logic tsub);
    a        = ta;
    b        = tb;
    cin      = tcin;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    sub      = tsub;
`else
    if (tsub) $display("[TB] sub requested without subtract support");
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    sub = 1'b0;
`endif
    for (int g = 0; g < 3; g++) begin
      sv_in_valid[g] = 1'b0; sv_a[g] = '0; sv_b[g] = '0; sv_cin[g] = 1'b0;
    end
    #12;
    tests_run++;
    if (sum !== 64'd0 || cout !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_state: sum=%h cout=%b out_valid=%b in_ready=%b, want 0/0/0/1", sum, cout, out_valid, in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_add;
    int cyc;
    issue(64'h3EB1E0033EBF3EBF, 64'h5555555555555555, 1'b0, 1'b0);
    wait_out(cyc);
    tests_run++;
    if (cyc !== 8) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d edges, want 8", cyc);
    end
    tests_run++;
    if (sum !== 64'h9407355894149414 || cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_sum: got %h cout=%b, want 9407355894149414 cout=0", sum, cout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_carry_ripple;
    int cyc;
    issue(64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1, 1'b0);
    wait_out(cyc);
    tests_run++;
    if (cyc !== 8 || sum !== 64'd0 || cout !== 1'b1) begin
      tests_failed++;
      $display("FAIL ripple_all_ones: got sum=%h cout=%b lat=%0d, want 0 cout=1 lat=8", sum, cout, cyc);
    end
    @(posedge clk); #1;
    issue(64'd0, 64'd0, 1'b1, 1'b0);
    wait_out(cyc);
    tests_run++;
    if (sum !== 64'd1 || cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL ripple_cin_only: got sum=%h cout=%b, want 1 cout=0", sum, cout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int cyc;
    out_ready = 1'b0;
    issue(64'h00000000000000FF, 64'h0000000000000001, 1'b0, 1'b0);
    wait_out(cyc);
    tests_run++;
    if (cyc !== 8 || sum !== 64'h100 || cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_result: got sum=%h cout=%b lat=%0d, want 100 cout=0 lat=8", sum, cout, cyc);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a        = {32'hDEADBEEF, i};
      @(posedge clk); #1;
      tests_run++;
      if (sum !== 64'h100 || cout !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: sum=%h cout=%b ov=%b ir=%b, want 100/0/1/0", i, sum, cout, out_valid, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release: ov=%b ir=%b, want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    issue(64'h5555555555555555, 64'h1111111111111111, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (sum !== 64'd0 || cout !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_run: sum=%h cout=%b ov=%b ir=%b, want 0/0/0/1", sum, cout, out_valid, in_ready);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) cyc++;
    end
    tests_run++;
    if (cyc !== 0) begin
      tests_failed++;
      $display("FAIL reset_no_pulse: out_valid seen high %0d cycles, want 0", cyc);
    end
    issue(64'd1, 64'd2, 1'b0, 1'b0);
    wait_out(cyc);
    tests_run++;
    if (cyc !== 8 || sum !== 64'd3 || cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_recover: sum=%h cout=%b lat=%0d, want 3 cout=0 lat=8", sum, cout, cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int cyc;
    issue(64'h8000000000000000, 64'h8000000000000000, 1'b0, 1'b0);
    wait_out(cyc);
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_ready: in_ready=%b, want 1", in_ready);
    end
    issue(64'h0000000100000000, 64'h00000000FFFFFFFF, 1'b1, 1'b0);
    wait_out(cyc);
    tests_run++;
    if (cyc !== 8 || sum !== 64'h0000000200000000 || cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_second: sum=%h cout=%b lat=%0d, want 0000000200000000 cout=0 lat=8", sum, cout, cyc);
    end
    @(posedge clk); #1;
  endtask

`ifdef SEQ_CHUNK_ADDER_SUB_EN
  task automatic test_sub;
    int cyc;
    issue(64'd5, 64'd7, 1'b1, 1'b1);
    wait_out(cyc);
    tests_run++;
    if (sum !== 64'hFFFFFFFFFFFFFFFE || cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL sub_borrow: sum=%h cout=%b, want FFFFFFFFFFFFFFFE cout=0", sum, cout);
    end
    @(posedge clk); #1;
    issue(64'd7, 64'd5, 1'b0, 1'b1);
    wait_out(cyc);
    tests_run++;
    if (sum !== 64'd2 || cout !== 1'b1) begin
      tests_failed++;
      $display("FAIL sub_no_borrow: sum=%h cout=%b, want 2 cout=1", sum, cout);
    end
    @(posedge clk); #1;
    sub = 1'b0;
  endtask
`endif

  task automatic test_sweep;
    logic [63:0] va [3];
    logic [63:0] vb [3];
    logic        vc [3];
    int          lat_exp [3];
    logic [64:0] ref_v;
    int          cyc;
    va = '{64'hFFFFFFFFFFFFFFFF, 64'h0123456789ABCDEF, 64'hA5A5A5A5F0F0F0F0};
    vb = '{64'd0,                64'hFEDCBA9876543210, 64'h5A5A5A5A0F0F0F0F};
    vc = '{1'b1, 1'b1, 1'b0};
    lat_exp = '{64, 4, 1};
    for (int g = 0; g < 3; g++) begin
      for (int v = 0; v < 3; v++) begin
        ref_v = {1'b0, va[v]} + {1'b0, vb[v]} + {64'd0, vc[v]};
        sv_a[g] = va[v]; sv_b[g] = vb[v]; sv_cin[g] = vc[v];
        sv_in_valid[g] = 1'b1;
        @(posedge clk); #1;
        sv_in_valid[g] = 1'b0;
        sv_a[g] = '0; sv_b[g] = '1;
        cyc = 0;
        while (sv_out_valid[g] !== 1'b1 && cyc < 200) begin
          @(posedge clk); #1;
          cyc++;
        end
        tests_run++;
        if (cyc !== lat_exp[g] || sv_sum[g] !== ref_v[63:0] || sv_cout[g] !== ref_v[64]) begin
          tests_failed++;
          $display("FAIL sweep_%0d_%0d: sum=%h cout=%b lat=%0d, want %h cout=%b lat=%0d",
                   g, v, sv_sum[g], sv_cout[g], cyc, ref_v[63:0], ref_v[64], lat_exp[g]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry_ripple();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    test_sub();
`endif
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
